multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle main decoder. A Moore FSM that sequences each RV32I-subset instruction through FETCH/DECODE/EXEC/MEM/WB.
- Emits per-state datapath controls and handshakes with a shared instruction/data memory (req/ready).
- Adds a configurable memory-wait timeout and a sticky HALT/ERROR.
- Sits between the IR/opcode field and the multi-cycle datapath, replacing the combinational decoder.

Parameters:
- MEM_TIMEOUT, 16: max cycles mem_req may wait for mem_ready before ERROR; 0 disables the timeout.
- ALUOP_W, 2: width of alu_op (00 LW/SW, 01 branch, 10 R/I-type, 11 JAL/JALR).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  7  instr[6:0] from the IR; sampled in DECODE
- mem_ready  in  1  memory completes the current request this cycle
- halt_req  in  1  external halt request, honoured at instruction boundary
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write enable qualifying mem_req (SW only)
- ir_write  out  1  load IR (FETCH and mem_ready)
- pc_write  out  1  PC <= PC+4 / target
- alu_src  out  1  0: rs2; 1: immediate
- mem_to_reg  out  1  writeback from memory data
- reg_write  out  1  register file write strobe
- alu_op  out  ALUOP_W  ALU operation class
- branch  out  1  branch/jalr target evaluation this cycle
- halt  out  1  sticky halted
- mem_err  out  1  sticky timeout error
- illegal_op  out  1  unrecognised opcode (see Optional Feature)

Behaviour:
- Opcodes:
  - R 0110011, I 0010011, LW 0000011, SW 0100011, BR 1100011, JAL 1101111, JALR 1100111, HALT 0000001.
- States: START, FETCH, DECODE, EXEC, MEM, WB, HALTED, ERROR.
  - Reset enters START. All outputs are 0 while reset is low and in START. START lasts exactly 1 cycle, then FETCH.
- FETCH:
  - mem_req=1, mem_we=0.
  - On mem_ready: ir_write=1, pc_write=1, go to DECODE. Otherwise stay.
  - If halt_req=1 on FETCH entry (the cycle before the first mem_req): go to HALTED instead; no request is issued.
- DECODE: opcode latched into opcode_q; all strobes 0; 1 cycle. HALT opcode goes to HALTED; every other opcode goes to EXEC.
- EXEC (1 cycle), keyed on opcode_q:
  - alu_src=1 for LW/SW/I.
  - alu_op per class.
  - BR: branch=1 -> FETCH.
  - JAL: reg_write=1, pc_write=1 -> FETCH.
  - JALR: reg_write=1, branch=1, pc_write=1 -> FETCH.
  - LW/SW -> MEM.
  - R/I -> WB.
- MEM:
  - mem_req=1, mem_we=(opcode_q==SW), alu_src=1.
  - On mem_ready: LW -> WB, SW -> FETCH.
- WB: reg_write=1 for 1 cycle; mem_to_reg=(opcode_q==LW); -> FETCH.
- Latency with zero-wait memory (mem_ready=1 on the first req cycle), FETCH to next FETCH:
  - BR/JAL/JALR/HALT-decode 3, R/I 4, SW 4, LW 5.
  - Each extra wait cycle adds 1.
- mem_req stays high and mem_we stays stable until the mem_ready handshake; both are dropped in the cycle after ready.
- Timeout:
  - Counter clears on entering FETCH or MEM and increments on each req cycle without ready.
  - When count == MEM_TIMEOUT and mem_ready=0: go to ERROR.
  - mem_ready in the same cycle the limit is reached wins: normal completion.
- HALTED and ERROR are absorbing; only reset exits them.
  - HALTED: halt=1.
  - ERROR: mem_err=1 and halt=1.
  - All other outputs 0.
- Reset asserted mid-operation: immediate return to START; any in-flight request is abandoned (mem_req drops asynchronously).
- halt_req arriving mid-instruction is ignored until the next FETCH entry; it is not latched.

Optional Feature:
- Macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
- Defined: an opcode outside the list goes DECODE -> ERROR with illegal_op=1 (sticky); mem_err stays 0.
- Undefined: unknown opcodes execute as NOP (DECODE -> EXEC with all strobes 0 -> FETCH, 3 cycles); illegal_op is tied 0.

Decomposition:
- Package ctrl_pkg:
  - opcode localparams (OPC_R ... OPC_HALT);
  - state_e enum;
  - ALUOp encoding constants (ALUOP_MEM, ALUOP_BR, ALUOP_ARITH, ALUOP_JUMP).
- Sub-module mem_wait_timer (params MEM_TIMEOUT; ports clk, reset, clear, waiting, expired).
- The FSM and output decode stay in multicycle_controller.

Test Plan:
- Reset then opcode 0110011 with mem_ready always 1 -> state sequence START, FETCH, DECODE, EXEC, WB, FETCH; reg_write=1 only in WB; alu_op=10.
- LW (0000011), mem_ready delayed 3 cycles in MEM -> mem_req high 4 cycles, mem_we=0 throughout, then WB with mem_to_reg=1; 8 cycles FETCH to FETCH.
- SW with MEM_TIMEOUT=4, mem_ready never asserted -> ERROR after 5 req cycles; mem_err=1 and halt=1, sticky; reset returns to START.
- Opcode 0000001 -> HALTED after DECODE; halt=1; no further mem_req for 20 cycles.
- halt_req=1 at FETCH entry with opcode BR in flight earlier -> BR completes (branch=1 in EXEC), then HALTED with no fetch issued.
- Opcode 1111111: with MULTICYCLE_CTRL_ILLEGAL_TRAP_EN -> ERROR with illegal_op=1; without -> back to FETCH after 3 cycles, no strobes asserted.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared opcodes, ALU operation classes and FSM states for the
// multi-cycle controller.
package ctrl_pkg;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LW   = 7'b0000011;
    localparam logic [6:0] OPC_SW   = 7'b0100011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_HALT = 7'b0000001;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_ARITH = 2'b10;
    localparam logic [1:0] ALUOP_JUMP  = 2'b11;

    typedef enum logic [2:0] {
        ST_START,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALTED,
        ST_ERROR
    } state_e;

    function automatic logic is_known_opcode(input logic [6:0] opc);
        return opc inside {OPC_R, OPC_I, OPC_LW, OPC_SW,
                           OPC_BR, OPC_JAL, OPC_JALR, OPC_HALT};
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle: opcode, memory handshake,
// halt request and all per-state datapath strobes.
interface multicycle_controller_if #(
    parameter int ALUOP_W = 2
);
    logic [6:0]         opcode;
    logic               mem_ready;
    logic               halt_req;
    logic               mem_req;
    logic               mem_we;
    logic               ir_write;
    logic               pc_write;
    logic               alu_src;
    logic               mem_to_reg;
    logic               reg_write;
    logic [ALUOP_W-1:0] alu_op;
    logic               branch;
    logic               halt;
    logic               mem_err;
    logic               illegal_op;

    modport master (
        input  opcode, mem_ready, halt_req,
        output mem_req, mem_we, ir_write, pc_write, alu_src,
               mem_to_reg, reg_write, alu_op, branch, halt,
               mem_err, illegal_op
    );

    modport slave (
        output opcode, mem_ready, halt_req,
        input  mem_req, mem_we, ir_write, pc_write, alu_src,
               mem_to_reg, reg_write, alu_op, branch, halt,
               mem_err, illegal_op
    );
endinterface

// File: rtl/multicycle_controller_timer.sv
// Memory wait counter: counts request cycles without ready and flags
// when the wait limit is reached (MEM_TIMEOUT=0 never expires).
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic waiting,
    output logic expired
);
    localparam int CW =
        (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

    logic [CW-1:0] r_cnt;

    // Saturates at the limit so a disabled timer never wraps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_cnt <= '0;
        else if (clear)
            r_cnt <= '0;
        else if (waiting && r_cnt != LIMIT)
            r_cnt <= r_cnt + CW'(1);
    end

    assign expired = (MEM_TIMEOUT != 0) && (r_cnt == LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing RV32I-subset instructions through FETCH..WB.
// Optional: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN traps unknown opcodes.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int ALUOP_W     = 2
) (
    input  logic clk,
    input  logic reset,
    multicycle_controller_if.master bus
);
    state_e     r_state;
    state_e     w_next;
    state_e     w_bound;
    logic [6:0] r_opc;
    logic       w_wait;
    logic       w_clear;
    logic       w_expired;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    logic       r_illegal;
`endif

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_clear),
        .waiting (w_wait),
        .expired (w_expired)
    );

    assign w_clear = (w_next != r_state);
    // Instruction boundary: halt_req diverts the next fetch
    assign w_bound = bus.halt_req ? ST_HALTED : ST_FETCH;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_START;
            r_opc   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE)
                r_opc <= bus.opcode;
        end
    end

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_illegal <= 1'b0;
        else if (r_state == ST_DECODE && w_next == ST_ERROR)
            r_illegal <= 1'b1;
    end
    assign bus.illegal_op = r_illegal;
`else
    assign bus.illegal_op = 1'b0;
`endif

    always_comb begin
        w_next         = r_state;
        w_wait         = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.alu_src    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_op     = '0;
        bus.branch     = 1'b0;
        bus.halt       = 1'b0;
        bus.mem_err    = 1'b0;
        case (r_state)
            ST_START: w_next = w_bound;
            ST_FETCH: begin
                bus.mem_req = 1'b1;
                w_wait      = !bus.mem_ready;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    w_next       = ST_DECODE;
                end else if (w_expired) begin
                    w_next = ST_ERROR;
                end
            end
            ST_DECODE: begin
                if (bus.opcode == OPC_HALT)
                    w_next = ST_HALTED;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                else if (!is_known_opcode(bus.opcode))
                    w_next = ST_ERROR;
`endif
                else
                    w_next = ST_EXEC;
            end
            ST_EXEC: begin
                case (r_opc)
                    OPC_R: begin
                        bus.alu_op = ALUOP_W'(ALUOP_ARITH);
                        w_next     = ST_WB;
                    end
                    OPC_I: begin
                        bus.alu_src = 1'b1;
                        bus.alu_op  = ALUOP_W'(ALUOP_ARITH);
                        w_next      = ST_WB;
                    end
                    OPC_LW, OPC_SW: begin
                        bus.alu_src = 1'b1;
                        bus.alu_op  = ALUOP_W'(ALUOP_MEM);
                        w_next      = ST_MEM;
                    end
                    OPC_BR: begin
                        bus.branch = 1'b1;
                        bus.alu_op = ALUOP_W'(ALUOP_BR);
                        w_next     = w_bound;
                    end
                    OPC_JAL: begin
                        bus.reg_write = 1'b1;
                        bus.pc_write  = 1'b1;
                        bus.alu_op    = ALUOP_W'(ALUOP_JUMP);
                        w_next        = w_bound;
                    end
                    OPC_JALR: begin
                        bus.reg_write = 1'b1;
                        bus.branch    = 1'b1;
                        bus.pc_write  = 1'b1;
                        bus.alu_op    = ALUOP_W'(ALUOP_JUMP);
                        w_next        = w_bound;
                    end
                    default: w_next = w_bound;
                endcase
            end
            ST_MEM: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = (r_opc == OPC_SW);
                bus.alu_src = 1'b1;
                w_wait      = !bus.mem_ready;
                if (bus.mem_ready)
                    w_next = (r_opc == OPC_SW) ? w_bound : ST_WB;
                else if (w_expired)
                    w_next = ST_ERROR;
            end
            ST_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = (r_opc == OPC_LW);
                w_next         = w_bound;
            end
            ST_HALTED: bus.halt = 1'b1;
            ST_ERROR: begin
                bus.halt = 1'b1;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                bus.mem_err = !r_illegal;
`else
                bus.mem_err = 1'b1;
`endif
            end
            default: w_next = ST_START;
        endcase
    end

endmodule
